// File: rtl/i2c_slave_regfile8x8_if.sv
// I2C clock input plus the register-bus strobes of the I2C slave register file.
// SDA stays a plain inout on the block because it is open-drain.
interface i2c_slave_regfile8x8_if;
    logic       scl;
    logic       reg_wen;
    logic       reg_ren;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    modport slave  (input scl, output reg_wen, reg_ren, reg_addr, reg_wdata, reg_rdata);
    modport master (output scl, input reg_wen, reg_ren, reg_addr, reg_wdata, reg_rdata);
endinterface

// File: rtl/i2c_slave_regfile8x8.sv
// Oversampled I2C slave with an 8x8 register file behind an auto-incrementing pointer.
// reset_n is active-high despite its name.
module i2c_slave_regfile8x8 #(
    parameter logic [6:0] SLAVE_ID = 7'h50
) (
    input  logic                         sys_clk,
    input  logic                         reset_n,
    inout  wire                          sda,
    i2c_slave_regfile8x8_if.slave        bus
);
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sh_q, sh_d, tx_q, tx_d, addr_q, addr_d, wdata_q, wdata_d;
    logic       rw_q, rw_d, oe_q, oe_d, wen_q, wen_d, ren_q, ren_d;
    logic [7:0] regs [8];
    logic [7:0] byte_in, addr_inc, rdata, rdata_nx;

    // [0],[1] synchronize, [2] is history; reset to 1 so an idle bus shows no edge
    logic [2:0] scl_s, sda_s;
    always_ff @(posedge sys_clk or posedge reset_n) begin
        if (reset_n) begin
            scl_s <= '1;
            sda_s <= '1;
        end else begin
            scl_s <= {scl_s[1:0], bus.scl};
            sda_s <= {sda_s[1:0], sda};
        end
    end

    logic scl_rise, scl_fall, scl_high, start_c, stop_c, sda_bit;
    assign scl_rise = scl_s[1] & ~scl_s[2];
    assign scl_fall = ~scl_s[1] & scl_s[2];
    assign scl_high = scl_s[1] & scl_s[2];
    assign start_c  = scl_high & ~sda_s[1] & sda_s[2];
    assign stop_c   = scl_high & sda_s[1] & ~sda_s[2];
    assign sda_bit  = sda_s[1];

    assign addr_inc = addr_q + 8'd1;
    assign rdata    = regs[addr_q[2:0]];
    assign rdata_nx = regs[addr_inc[2:0]];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wen_d     = 1'b0;
        ren_d     = 1'b0;
        byte_in   = {sh_q[6:0], sda_bit};
        if (start_c) begin
            state_d   = DEV_ADDR;
            bit_cnt_d = '0;
            sh_d      = '0;
            oe_d      = 1'b0;
        end else if (stop_c) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                DEV_ADDR, REG_ADDR, WR_DATA: if (scl_rise) begin
                    sh_d      = byte_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = '0;
                        case (state_q)
                            DEV_ADDR: if (byte_in[7:1] == SLAVE_ID) begin
                                rw_d    = byte_in[0];
                                state_d = ACK_DEV;
                            end else begin
                                state_d = IGNORE;
                            end
                            REG_ADDR: begin
                                addr_d  = byte_in;
                                state_d = ACK_REG;
                            end
                            default: begin
                                wdata_d = byte_in;
                                wen_d   = 1'b1;
                                state_d = ACK_WR;
                            end
                        endcase
                    end
                end
                // first fall after bit 8 pulls SDA low, the fall after bit 9 ends the ACK
                ACK_DEV, ACK_REG, ACK_WR: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d = 1'b0;
                        case (state_q)
                            ACK_DEV: if (rw_q) begin
                                ren_d     = 1'b1;
                                tx_d      = rdata;
                                oe_d      = ~rdata[7];
                                bit_cnt_d = '0;
                                state_d   = RD_DATA;
                            end else begin
                                state_d = REG_ADDR;
                            end
                            ACK_REG: state_d = WR_DATA;
                            default: begin
                                addr_d  = addr_inc;
                                state_d = WR_DATA;
                            end
                        endcase
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = RD_ACK;
                        end else begin
                            oe_d = ~tx_q[3'd7 - bit_cnt_q[2:0]];
                        end
                    end
                end
                RD_ACK: if (scl_rise) begin
                    if (!sda_bit) begin
                        addr_d    = addr_inc;
                        ren_d     = 1'b1;
                        tx_d      = rdata_nx;
                        bit_cnt_d = '0;
                        state_d   = RD_DATA;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset_n) begin
        if (reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            tx_q      <= '0;
            rw_q      <= 1'b0;
            oe_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            ren_q     <= ren_d;
        end
    end

    always_ff @(posedge sys_clk or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (wen_q) begin
            regs[addr_q[2:0]] <= wdata_q;
        end
    end

    assign sda           = oe_q ? 1'b0 : 1'bz;
    assign bus.reg_wen   = wen_q;
    assign bus.reg_ren   = ren_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_rdata = rdata;
endmodule

// File: tb/tb_i2c_slave_regfile8x8.sv
// Directed bench: bit-banged I2C master, scoreboards for register writes and read bytes.
module tb_i2c_slave_regfile8x8;
    localparam int Q = 8;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;
    logic m_low   = 1'b0;
    wire  sda;

    i2c_slave_regfile8x8_if bus ();
    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_regfile8x8 #(.SLAVE_ID(7'h50)) dut (
        .sys_clk(sys_clk),
        .reset_n(reset_n),
        .sda    (sda),
        .bus    (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int         errors = 0, checks = 0;
    int         wen_cnt = 0, drv_cnt = 0;
    logic [15:0] wq [$];
    logic [7:0]  rq [$];
    logic [7:0]  mem [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance on falling sys_clk edges, monitoring slave drive and write strobes
    task automatic tick(input int n);
        logic [15:0] e;
        repeat (n) begin
            @(negedge sys_clk);
            if (sda === 1'b0 && !m_low) drv_cnt++;
            if (bus.reg_wen) begin
                wen_cnt++;
                chk("wen_expected", 32'(wq.size() > 0), 32'd1);
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("wen_addr", 32'(bus.reg_addr), 32'(e[15:8]));
                    chk("wen_data", 32'(bus.reg_wdata), 32'(e[7:0]));
                end
            end
        end
    endtask

    task automatic i2c_start();
        m_low = 1'b0; tick(Q);
        bus.scl = 1'b1; tick(Q);
        m_low = 1'b1; tick(Q);
        bus.scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; tick(Q);
        bus.scl = 1'b1; tick(Q);
        m_low = 1'b0; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; tick(Q);
        bus.scl = 1'b1; tick(2*Q);
        bus.scl = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0; tick(Q);
        bus.scl = 1'b1; tick(Q);
        b = (sda !== 1'b0);
        tick(Q);
        bus.scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    task automatic set_ptr(input logic [7:0] addr);
        logic a;
        i2c_start();
        send_byte(8'hA0, a); chk("ack_id_w", 32'(a), 32'd1);
        send_byte(addr, a);  chk("ack_reg", 32'(a), 32'd1);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] d);
        logic a;
        set_ptr(addr);
        wq.push_back({addr, d});
        mem[addr[2:0]] = d;
        send_byte(d, a); chk("ack_wr", 32'(a), 32'd1);
        i2c_stop();
    endtask

    task automatic rd(input logic [7:0] addr, input int n);
        logic       a;
        logic [7:0] d, ra;
        set_ptr(addr);
        i2c_start();
        send_byte(8'hA1, a); chk("ack_id_r", 32'(a), 32'd1);
        for (int k = 0; k < n; k++) begin
            ra = addr + 8'(k);
            rq.push_back(mem[ra[2:0]]);
            recv_byte(d, k != n - 1);
            chk("rd_data", 32'(d), 32'(rq.pop_front()));
        end
        i2c_stop();
        chk("rd_sda_released", 32'(sda), 32'd1);
    endtask

    initial begin
        int         w0, d0;
        logic       a;
        logic [7:0] bursts [3];
        bus.scl = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        bursts[0] = 8'h11; bursts[1] = 8'h22; bursts[2] = 8'h33;

        // 1: reset state, then read all eight registers
        reset_n = 1'b1; tick(4);
        chk("rst_wen", 32'(bus.reg_wen), 32'd0);
        chk("rst_ren", 32'(bus.reg_ren), 32'd0);
        chk("rst_addr", 32'(bus.reg_addr), 32'd0);
        chk("rst_wdata", 32'(bus.reg_wdata), 32'd0);
        chk("rst_rdata", 32'(bus.reg_rdata), 32'd0);
        chk("rst_sda", 32'(sda), 32'd1);
        reset_n = 1'b0; tick(4);
        rd(8'h00, 8);
        chk("rd_burst_addr", 32'(bus.reg_addr), 32'h07);

        // 2: single write through an aliased address
        w0 = wen_cnt;
        wr(8'hC1, 8'h55);
        chk("wr_wen_count", 32'(wen_cnt - w0), 32'd1);
        chk("wr_queue_empty", 32'(wq.size()), 32'd0);
        chk("wr_sda_released", 32'(sda), 32'd1);

        // 3: combined read back of 0xC1
        rd(8'hC1, 1);

        // 4: foreign device address is ignored
        w0 = wen_cnt; d0 = drv_cnt;
        i2c_start();
        send_byte(8'hA2, a); chk("nack_bad_id", 32'(a), 32'd0);
        send_byte(8'h5A, a); chk("nack_ignored", 32'(a), 32'd0);
        i2c_stop();
        chk("bad_id_no_drive", 32'(drv_cnt - d0), 32'd0);
        chk("bad_id_no_wen", 32'(wen_cnt - w0), 32'd0);
        i2c_start();
        send_byte(8'hA0, a); chk("ack_after_ignore", 32'(a), 32'd1);
        i2c_stop();

        // 5: burst write wrapping 7 -> 0 in the register file
        set_ptr(8'h06);
        for (int k = 0; k < 3; k++) begin
            wq.push_back({8'h06 + 8'(k), bursts[k]});
            mem[3'(6 + k)] = bursts[k];
            send_byte(bursts[k], a); chk("ack_burst", 32'(a), 32'd1);
        end
        i2c_stop();
        chk("burst_addr_end", 32'(bus.reg_addr), 32'h09);
        chk("burst_queue_empty", 32'(wq.size()), 32'd0);
        rd(8'h06, 3);

        // 6a: STOP after four data bits writes nothing
        w0 = wen_cnt;
        set_ptr(8'h02);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        chk("partial_no_wen", 32'(wen_cnt - w0), 32'd0);
        rd(8'h02, 1);

        // 6b: reset while the slave is holding the ACK low
        w0 = wen_cnt;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
        m_low = 1'b0; tick(2);
        chk("ack_driven", 32'(sda), 32'd0);
        bus.scl = 1'b1; tick(Q);
        reset_n = 1'b1; tick(1);
        chk("rst_mid_ack_sda", 32'(sda), 32'd1);
        chk("rst_mid_ack_addr", 32'(bus.reg_addr), 32'd0);
        reset_n = 1'b0; tick(Q);
        bus.scl = 1'b0; tick(Q);
        i2c_stop();
        chk("rst_no_wen", 32'(wen_cnt - w0), 32'd0);
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        rd(8'h00, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
